// File: rtl/regfile_write_port.sv
// Write port for a 32-entry register file: queues write requests in a small FIFO
// and commits one per cycle as a registered one-hot enable plus data, discarding X31.
module regfile_write_port #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hold,
    output logic [31:0]      en,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [31:0]      en_reg, en_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [7:0]       drop_cnt_reg, drop_cnt_next;

    logic [4:0]       addr_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];

    logic             push, pop;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;
    logic             head_is_zero_reg;
    logic [3:0]       dec_hi;
    logic [7:0]       dec_lo;
    logic [31:0]      head_onehot;

    assign wr_ready = (count_reg < FULL_COUNT);
    assign busy     = (count_reg != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = busy && !hold;

    // Head is read combinationally so a pop commits in the same edge it is decided.
    assign head_addr        = addr_mem[rd_ptr_reg];
    assign head_data        = data_mem[rd_ptr_reg];
    assign head_is_zero_reg = (head_addr == 5'd31);

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= wr_addr;
            data_mem[wr_ptr_reg] <= wr_data;
        end
    end

    // 5->32 decode as a 2->4 on the upper bits ANDed with a 3->8 on the lower bits.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec_hi
            assign dec_hi[gi] = (head_addr[4:3] == 2'(gi));
        end
        for (gi = 0; gi < 8; gi++) begin : g_dec_lo
            assign dec_lo[gi] = (head_addr[2:0] == 3'(gi));
        end
        for (gi = 0; gi < 32; gi++) begin : g_dec_and
            assign head_onehot[gi] = dec_hi[gi / 8] & dec_lo[gi % 8];
        end
    endgenerate

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        en_next       = '0;
        dout_next     = dout_reg;
        drop_cnt_next = drop_cnt_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
            if (head_is_zero_reg) begin
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_next = drop_cnt_reg + 8'd1;
                end
            end else begin
                en_next   = head_onehot;
                dout_next = head_data;
            end
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            en_reg       <= '0;
            dout_reg     <= '0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            en_reg       <= en_next;
            dout_reg     <= dout_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign en       = en_reg;
    assign dout     = dout_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: stimulus queues expected commits,
// a negedge monitor pops and compares each enable pulse against them.
module tb_regfile_write_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        hold;
    logic [31:0] en;
    logic [63:0] dout;
    logic        busy;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    regfile_write_port #(.WIDTH(64), .DEPTH(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hold     (hold),
        .en       (en),
        .dout     (dout),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every enable pulse must be one-hot and match the oldest expected write.
    always @(negedge clk) begin
        total++;
        if ((en & (en - 32'd1)) != 32'd0) begin
            bad++;
            $display("FAIL en_onehot actual=%h required=onehot_or_zero", en);
        end
        if (en != 32'd0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual en=%h dout=%h required=no_write", en, dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_en", {32'd0, en}, {32'd0, 32'd1 << e.a});
                chk("sb_dout", dout, e.d);
            end
        end
    end

    // Presents one request at a negedge, waits (bounded) for acceptance, returns at the next negedge.
    task automatic send(input logic [4:0] a, input logic [63:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=wr_ready_low required=accept addr=%0d", a);
        end else if (a != 5'd31) begin
            exp_q.push_back('{a: a, d: d});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        wr_valid = 1'b0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {63'd0, (busy || exp_q.size() != 0)}, 64'd0);
        @(negedge clk);
    endtask

    logic [63:0] dout_before;

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 64'd0;
        hold     = 1'b0;
        #2;
        chk("rst_en", {32'd0, en}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write: one-cycle latency after acceptance, one-cycle pulse.
        send(5'd5, 64'hDEAD_BEEF_0000_0001);
        wr_valid = 1'b0;
        chk("single_latency_en", {32'd0, en}, 64'd0);
        chk("single_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("single_en", {32'd0, en}, 64'h0000_0020);
        chk("single_dout", dout, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        chk("single_en_clear", {32'd0, en}, 64'd0);
        chk("single_idle", {63'd0, busy}, 64'd0);

        // Back-to-back under hold: FIFO fills, third request refused.
        hold = 1'b1;
        send(5'd3, 64'h0000_0000_0000_0303);
        send(5'd7, 64'h0000_0000_0000_0707);
        wr_valid = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 64'h0000_0000_0000_0909;
        chk("full_ready", {63'd0, wr_ready}, 64'd0);
        @(negedge clk);
        chk("full_ready_hold", {63'd0, wr_ready}, 64'd0);
        chk("full_en_hold", {32'd0, en}, 64'd0);
        wr_valid = 1'b0;
        hold     = 1'b0;
        @(negedge clk);
        chk("b2b_en0", {32'd0, en}, 64'h8);
        chk("b2b_ready_after_pop", {63'd0, wr_ready}, 64'd1);
        @(negedge clk);
        chk("b2b_en1", {32'd0, en}, 64'h80);
        chk("b2b_dout1", dout, 64'h0000_0000_0000_0707);
        drain();

        // Zero register writes are dropped and counted, dout untouched.
        dout_before = dout;
        for (int i = 0; i < 3; i++) send(5'd31, 64'hFFFF_0000_0000_0000 + 64'(i));
        drain();
        chk("drop3_cnt", {56'd0, drop_cnt}, 64'd3);
        chk("drop3_dout", dout, dout_before);
        for (int i = 0; i < 251; i++) send(5'd31, 64'(i));
        drain();
        chk("drop254_cnt", {56'd0, drop_cnt}, 64'd254);
        for (int i = 0; i < 3; i++) send(5'd31, 64'(i));
        drain();
        chk("drop_sat_cnt", {56'd0, drop_cnt}, 64'd255);

        // Continuous stream across all addresses with simultaneous push/pop.
        for (int i = 0; i < 32; i++) begin
            send(5'(i), 64'hC0DE_0000_0000_0000 | 64'(i));
            chk("stream_busy", {63'd0, busy}, 64'd1);
        end
        drain();
        chk("stream_drop_sat", {56'd0, drop_cnt}, 64'd255);

        // Hold for 4 cycles in the middle of a stream.
        fork
            begin
                for (int i = 0; i < 12; i++) send(5'(i + 1), 64'h1234_0000_0000_0000 | 64'(i));
                wr_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                hold = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("hold_en_zero", {32'd0, en}, 64'd0);
                end
                chk("hold_ready_full", {63'd0, wr_ready}, 64'd0);
                hold = 1'b0;
            end
        join
        drain();

        // Asynchronous reset with two entries queued: queued writes are lost.
        hold = 1'b1;
        send(5'd10, 64'hBAD0_0000_0000_0010);
        send(5'd11, 64'hBAD0_0000_0000_0011);
        wr_valid = 1'b0;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_en", {32'd0, en}, 64'd0);
        chk("mid_rst_dout", dout, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, wr_ready}, 64'd1);
        chk("mid_rst_drop", {56'd0, drop_cnt}, 64'd0);
        hold = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_en", {32'd0, en}, 64'd0);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
